decode_exec_stage: RTL
======================

DECODE_EXEC_STAGE -- requirements
Module: decode_exec_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of output buffer entries; legal range 1..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  discard all buffered entries.
REQ-005 SHALL have port in_valid  input  1  upstream instruction fields valid.
REQ-006 SHALL have port in_ready  output  1  stage accepts input this cycle.
REQ-007 SHALL have port opcode  input  7  instruction opcode.
REQ-008 SHALL have port funct3  input  3  instruction funct3.
REQ-009 SHALL have port funct7  input  7  instruction funct7.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head.
REQ-012 SHALL have port exec_op  output  4  execution operation of head entry.
REQ-013 SHALL have port operand1_sel  output  1  0 = register, 1 = PC.
REQ-014 SHALL have port operand2_sel  output  1  0 = register, 1 = immediate.
REQ-015 SHALL have port is_muldiv  output  1  head entry is an M-extension op.

Function
REQ-016 SHALL decode exec_op as {funct7[5],funct3} for OP (0110011); {funct3==101 & funct7[5], funct3} for OP_IMM (0010011); 4'b0000 (ADD) otherwise.
REQ-017 SHALL decode selects: OP -> reg/reg; BRANCH (1100011), JAL (1101111), AUIPC (0010111) -> PC/imm; all other opcodes -> reg/imm.
REQ-018 SHALL store decoded fields in a DEPTH-entry FIFO; push on in_valid & in_ready, pop on out_valid & out_ready.
REQ-019 SHALL drive in_ready = (count < DEPTH) & !reset; no bypass, so when full in_ready is 0 even if a pop occurs that cycle.
REQ-020 SHALL drive out_valid = (count != 0); latency from accept to out_valid is exactly 1 cycle.
REQ-021 SHALL drive exec_op, operand1_sel, operand2_sel and is_muldiv from the head entry when out_valid is 1, and all zero when empty.
REQ-022 SHALL keep count unchanged on simultaneous push and pop; read/write pointers wrap from DEPTH-1 to 0 for any DEPTH, including non-powers of two.
REQ-023 SHALL, on flush, set count and both pointers to 0 at the next edge; a push in the flush cycle is discarded.
REQ-024 SHALL hold head outputs stable while out_valid & !out_ready.

Reset
REQ-025 SHALL, while reset is high, force count, pointers and all entries to 0 at each edge; out_valid = 0, all field outputs = 0, in_ready = 0.
REQ-026 SHALL treat reset asserted mid-transfer as dominating push, pop and flush; no entry survives.

Configuration
REQ-027 SHALL, with RV32M_DECODE_EN defined, decode OP with funct7 = 0000001 as is_muldiv = 1, exec_op = {1'b0,funct3}, selects reg/reg.
REQ-028 SHALL, without RV32M_DECODE_EN, tie is_muldiv to 0 and decode funct7 = 0000001 per REQ-016.

Verification
REQ-029 SHALL cover: push OP funct3=000 funct7=0100000 -> next cycle out_valid=1, exec_op=1000, sel reg/reg.
REQ-030 SHALL cover: OP_IMM funct3=101 funct7=0100000 then funct3=000 funct7=0100000 -> exec_op=1101 then 0000, sel reg/imm.
REQ-031 SHALL cover: DEPTH=2, out_ready=0, push 3 JAL -> in_ready=0 after 2 pushes, third held; out_ready=1 -> drained in order, sel PC/imm.
REQ-032 SHALL cover: DEPTH=3, continuous push and pop for 10 cycles -> count constant, pointers wrap, order preserved.
REQ-033 SHALL cover: flush with 2 entries plus concurrent push -> next cycle out_valid=0, in_ready=1, outputs zero.
REQ-034 SHALL cover: OP funct3=100 funct7=0000001 -> is_muldiv=1, exec_op=0100 with RV32M_DECODE_EN; is_muldiv=0, exec_op=0100 without.

Source files
------------

// File: rtl/decode_exec_stage.sv
// Decode stage: maps RV32 opcode/funct3/funct7 to an exec op and operand selects, buffered in a DEPTH-entry FIFO.
// Latency: one cycle from an accepted input to out_valid; the head is registered state with no input bypass.
// Backpressure: in_ready drops when the buffer is full, even if a pop happens that cycle. Optional M decode is enabled by RV32M_DECODE_EN.
module decode_exec_stage #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] exec_op,
    output logic       operand1_sel,
    output logic       operand2_sel,
    output logic       is_muldiv
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

`ifdef RV32M_DECODE_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       is_muldiv;
        logic       op1_sel;
        logic       op2_sel;
        logic [3:0] exec_op;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign in_ready  = (count < CNT_MAX) & ~reset;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Instruction field decode; default is ADD with register/immediate operands.
    always_comb begin
        dec         = '0;
        dec.op2_sel = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.op2_sel = 1'b0;
                dec.exec_op = {funct7[5], funct3};
                if (MULDIV_EN && (funct7 == 7'b0000001)) begin
                    dec.is_muldiv = 1'b1;
                    dec.exec_op   = {1'b0, funct3};
                end
            end
            OPC_OP_IMM: begin
                // Only the shift-right encoding carries the arithmetic bit in funct7[5].
                dec.exec_op = {(funct3 == 3'b101) & funct7[5], funct3};
            end
            OPC_BRANCH, OPC_JAL, OPC_AUIPC: begin
                dec.op1_sel = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Pointer and occupancy bookkeeping; reset dominates flush, flush dominates push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a push in a flush cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Head fields are forced to zero whenever the buffer is empty.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign exec_op      = head.exec_op;
    assign operand1_sel = head.op1_sel;
    assign operand2_sel = head.op2_sel;
    assign is_muldiv    = head.is_muldiv;

endmodule
